sa_2x2_feeder: RTL and testbench
================================

Name: sa_2x2_feeder

Overview:
- Upstream operand sequencer for the 2x2 systolic PE array (SA_2x2).
- Holds a 4x4 input tile A and a 3x3 kernel B in local register files.
- On start, streams the 9-step sliding-window sequence: four A operands plus one broadcast B weight per cycle. The array accumulates the 2x2 convolution outputs C11..C22 from this stream.
- Brackets the stream with an accumulator-clear cycle, a zero-flush cycle and a done pulse.

Parameters:
- DATA_W, 8, operand width of A, B and all operand outputs.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  operand-store write strobe.
- wr_sel  in  1  0 = A store, 1 = B store.
- wr_addr  in  4  row-major index. A: row*4+col (0..15). B: row*3+col (0..8).
- wr_data  in  DATA_W  write data.
- start  in  1  start request, sampled in IDLE only.
- busy  out  1  high from CLR through DONE.
- done  out  1  one-cycle completion pulse.
- acc_clr  out  1  one-cycle clear for the PE accumulators.
- op_valid  out  1  high while operands on the bus are a real MAC step.
- a_11, a_12, a_21, a_22  out  DATA_W each  per-PE A operands.
- b_bcast  out  DATA_W  kernel weight broadcast to all four PEs.
- step  out  4  current step index 0..8, 0 outside STREAM.

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE.
  - All outputs are 0.
  - Both stores are cleared to 0.
  - Step counter is 0.
  - Applies mid-operation too: the stream aborts immediately and no done pulse is generated.
- Stores:
  - Writes are accepted only in IDLE; writes while busy are dropped.
  - B writes with wr_addr > 8 are dropped.
  - A write and start in the same IDLE cycle: both take effect. The write is visible to the stream because the first read occurs 2 cycles later.
- All outputs are registered.
- FSM states:
  - IDLE: start=1 -> CLR.
  - CLR (1 cycle): acc_clr=1, busy=1, op_valid=0, operands 0 -> STREAM.
  - STREAM (9 cycles, k = 0..8): r = k/3, c = k%3, 0-based indices.
    - a_11 = A[r][c], a_12 = A[r][c+1], a_21 = A[r+1][c], a_22 = A[r+1][c+1].
    - b_bcast = B[2-r][2-c]; the kernel is traversed in reverse, i.e. true convolution.
    - op_valid=1, step=k.
    - Moves to FLUSH after k=8.
  - FLUSH (1 cycle): all operands 0, op_valid=0 -> DONE.
  - DONE (1 cycle): done=1, busy=1 -> IDLE.
- Timing:
  - start sampled high at edge T gives acc_clr at T+1, first op_valid at T+2, last op_valid at T+10, FLUSH at T+11, done at T+12.
  - Back-to-back: start may be asserted during DONE but is ignored. The earliest accepted start is the first IDLE cycle.
- start while busy is ignored.
- Stores are not modified by streaming, so a second start replays identical operands.
- No arithmetic is done in this block; operands pass through unmodified at DATA_W.

Optional Feature:
- Macro: SA_FEEDER_STALL_EN.
- Defined: adds input port stall (1 bit).
  - In STREAM with stall=1: step counter and operand registers hold, op_valid=0.
  - Streaming resumes at the same k when stall=0.
  - stall is ignored in CLR, FLUSH and DONE.
  - Latency from start to done is 12 + number of stalled STREAM cycles.
- Undefined: port absent; stream runs uninterrupted.

Decomposition:
- Shared package sa_pkg holds:
  - the FSM state enum (IDLE, CLR, STREAM, FLUSH, DONE);
  - constants A_DIM=4, K_DIM=3, N_STEPS=9, STEP_W=4.
- One sub-module: sa_operand_store.
  - Contains the 16+9 entry register file with write port, async clear, one 4-wide A read and one B read.
  - Window index math stays in sa_2x2_feeder.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles, then release -> all outputs 0, busy=0. Start with empty stores -> 9 op_valid cycles with all operands 0, done at T+12.
- Golden stream:
  - Load A rows {2,1,3,1},{2,3,2,1},{3,2,2,2},{1,1,1,2} and B rows {1,3,1},{2,1,2},{1,1,3}, then pulse start.
  - step0 -> (2,1,2,3), b=3. step4 -> (3,2,2,2), b=1. step8 -> (2,2,1,2), b=1.
  - acc_clr at T+1, done at T+12, FLUSH operands 0.
- Protocol: writes to A[0] (value 9) and B[9] while busy, plus start at T+5 -> all dropped. A replay start after done gives an identical stream (step0 a_11=2).
- Reset mid-stream: drive reset=0 at step 4 -> outputs 0 asynchronously, no done pulse, stores read 0 afterwards.
- Same-cycle write+start: write A[0]=7 together with start -> step0 a_11=7.
- Stall (SA_FEEDER_STALL_EN defined): stall=1 for 3 cycles at step 2 -> step holds at 2, op_valid=0 while stalled, done at T+15.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and constants for the 2x2 systolic-array operand feeder.
package sa_pkg;

   localparam int unsigned A_DIM   = 4;
   localparam int unsigned K_DIM   = 3;
   localparam int unsigned N_STEPS = 9;
   localparam int unsigned STEP_W  = 4;

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StStream,
      StFlush,
      StDone
   } sa_state_e;

endpackage

// File: rtl/sa_operand_store.sv
// Operand register file: 16-entry A tile and 9-entry B kernel, one write port,
// a 2x2 A window read at a base address and one B read.
module sa_operand_store
   import sa_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic              wr_sel_i,
   input  logic [3:0]        wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [3:0]        a_base_i,
   input  logic [3:0]        b_addr_i,
   output logic [DATA_W-1:0] a_11_o,
   output logic [DATA_W-1:0] a_12_o,
   output logic [DATA_W-1:0] a_21_o,
   output logic [DATA_W-1:0] a_22_o,
   output logic [DATA_W-1:0] b_o
);

   logic [DATA_W-1:0] a_q [A_DIM*A_DIM];
   logic [DATA_W-1:0] b_q [K_DIM*K_DIM];

   logic [3:0] a12_addr, a21_addr, a22_addr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(A_DIM * A_DIM); i++) a_q[i] <= '0;
         for (int i = 0; i < int'(K_DIM * K_DIM); i++) b_q[i] <= '0;
      end else if (wr_en_i) begin
         if (!wr_sel_i) begin
            a_q[wr_addr_i] <= wr_data_i;
         end else if (wr_addr_i <= 4'(K_DIM * K_DIM - 1)) begin
            b_q[wr_addr_i] <= wr_data_i;
         end
      end
   end

   always_comb begin
      a12_addr = a_base_i + 4'd1;
      a21_addr = a_base_i + 4'(A_DIM);
      a22_addr = a_base_i + 4'(A_DIM + 1);
   end

   assign a_11_o = a_q[a_base_i];
   assign a_12_o = a_q[a12_addr];
   assign a_21_o = a_q[a21_addr];
   assign a_22_o = a_q[a22_addr];
   assign b_o    = b_q[b_addr_i];

endmodule

// File: rtl/sa_2x2_feeder.sv
// Operand sequencer for the 2x2 systolic PE array: CLR, 9 sliding-window steps, FLUSH, DONE.
// Define SA_FEEDER_STALL_EN to add the stall_i input that freezes the stream.
module sa_2x2_feeder
   import sa_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic              wr_sel_i,
   input  logic [3:0]        wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              start_i,
`ifdef SA_FEEDER_STALL_EN
   input  logic              stall_i,
`endif
   output logic              busy_o,
   output logic              done_o,
   output logic              acc_clr_o,
   output logic              op_valid_o,
   output logic [DATA_W-1:0] a_11_o,
   output logic [DATA_W-1:0] a_12_o,
   output logic [DATA_W-1:0] a_21_o,
   output logic [DATA_W-1:0] a_22_o,
   output logic [DATA_W-1:0] b_bcast_o,
   output logic [STEP_W-1:0] step_o
);

   sa_state_e state_q, state_d;
   logic [STEP_W-1:0] k_q, k_d;

   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              clr_q, clr_d;
   logic              vld_q, vld_d;
   logic [DATA_W-1:0] a11_q, a11_d, a12_q, a12_d, a21_q, a21_d, a22_q, a22_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [STEP_W-1:0] step_q, step_d;

   logic              stall;
   logic              idle_ok;
   logic [3:0]        row, col, a_base, b_addr;
   logic [DATA_W-1:0] rd_a11, rd_a12, rd_a21, rd_a22, rd_b;

`ifdef SA_FEEDER_STALL_EN
   assign stall = stall_i;
`else
   assign stall = 1'b0;
`endif

   // Outputs lag the state by one cycle, so the DONE cycle is still visibly busy.
   assign idle_ok = (state_q == StIdle) && !busy_q;

   always_comb begin
      row    = (k_q >= 4'd6) ? 4'd2 : (k_q >= 4'd3) ? 4'd1 : 4'd0;
      col    = k_q - (row + row + row);
      a_base = (row << 2) + col;
      // Reverse kernel walk: B[2-r][2-c] collapses to index 8-k.
      b_addr = 4'(N_STEPS - 1) - k_q;
   end

   sa_operand_store #(
      .DATA_W (DATA_W)
   ) u_store (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (wr_en_i && idle_ok),
      .wr_sel_i  (wr_sel_i),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .a_base_i  (a_base),
      .b_addr_i  (b_addr),
      .a_11_o    (rd_a11),
      .a_12_o    (rd_a12),
      .a_21_o    (rd_a21),
      .a_22_o    (rd_a22),
      .b_o       (rd_b)
   );

   always_comb begin
      state_d = state_q;
      k_d     = '0;
      busy_d  = (state_q != StIdle);
      done_d  = 1'b0;
      clr_d   = 1'b0;
      vld_d   = 1'b0;
      a11_d   = '0;
      a12_d   = '0;
      a21_d   = '0;
      a22_d   = '0;
      b_d     = '0;
      step_d  = '0;
      unique case (state_q)
         StIdle: begin
            if (start_i && !busy_q) state_d = StClr;
         end
         StClr: begin
            clr_d   = 1'b1;
            state_d = StStream;
         end
         StStream: begin
            if (stall) begin
               k_d    = k_q;
               a11_d  = a11_q;
               a12_d  = a12_q;
               a21_d  = a21_q;
               a22_d  = a22_q;
               b_d    = b_q;
               step_d = step_q;
            end else begin
               vld_d  = 1'b1;
               a11_d  = rd_a11;
               a12_d  = rd_a12;
               a21_d  = rd_a21;
               a22_d  = rd_a22;
               b_d    = rd_b;
               step_d = k_q;
               if (k_q == 4'(N_STEPS - 1)) begin
                  state_d = StFlush;
               end else begin
                  k_d = k_q + 4'd1;
               end
            end
         end
         StFlush: begin
            state_d = StDone;
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clr_q   <= 1'b0;
         vld_q   <= 1'b0;
         a11_q   <= '0;
         a12_q   <= '0;
         a21_q   <= '0;
         a22_q   <= '0;
         b_q     <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         clr_q   <= clr_d;
         vld_q   <= vld_d;
         a11_q   <= a11_d;
         a12_q   <= a12_d;
         a21_q   <= a21_d;
         a22_q   <= a22_d;
         b_q     <= b_d;
         step_q  <= step_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign acc_clr_o  = clr_q;
   assign op_valid_o = vld_q;
   assign a_11_o     = a11_q;
   assign a_12_o     = a12_q;
   assign a_21_o     = a21_q;
   assign a_22_o     = a22_q;
   assign b_bcast_o  = b_q;
   assign step_o     = step_q;

endmodule

// File: tb/tb_sa_2x2_feeder.sv
// Self-checking bench for sa_2x2_feeder: phase-based reference model plus directed literals.
module tb_sa_2x2_feeder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic       wr_sel = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       start = 1'b0;
   logic       stall = 1'b0;

   logic       busy, done, acc_clr, op_valid;
   logic [7:0] a_11, a_12, a_21, a_22, b_bcast;
   logic [3:0] step;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   sa_2x2_feeder #(
      .DATA_W (8)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .wr_en_i    (wr_en),
      .wr_sel_i   (wr_sel),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .start_i    (start),
`ifdef SA_FEEDER_STALL_EN
      .stall_i    (stall),
`endif
      .busy_o     (busy),
      .done_o     (done),
      .acc_clr_o  (acc_clr),
      .op_valid_o (op_valid),
      .a_11_o     (a_11),
      .a_12_o     (a_12),
      .a_21_o     (a_21),
      .a_22_o     (a_22),
      .b_bcast_o  (b_bcast),
      .step_o     (step)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model. ph = output phase visible now: 0 idle, 1 clear, 2..10 steps 0..8,
   // 11 flush, 12 done. stl marks a stalled step (operands frozen, not valid).
   logic [7:0] am [16];
   logic [7:0] bm [9];
   int ph = 0;
   bit stl = 0;
   bit go = 0;
   bit mdl_ok = 0;
   logic stall_s;

`ifdef SA_FEEDER_STALL_EN
   assign stall_s = stall;
`else
   assign stall_s = 1'b0;
`endif

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) am[i] <= '0;
         for (int i = 0; i < 9; i++) bm[i] <= '0;
         ph     <= 0;
         stl    <= 0;
         go     <= 0;
         mdl_ok <= 1;
      end else begin
         if (wr_en && ph == 0 && !go) begin
            if (!wr_sel) am[wr_addr] <= wr_data;
            else if (wr_addr <= 4'd8) bm[wr_addr] <= wr_data;
         end
         go  <= start && ph == 0 && !go;
         stl <= 0;
         if (go) ph <= 1;
         else if (ph >= 1 && ph <= 9 && stall_s) stl <= 1;
         else if (ph == 12) ph <= 0;
         else if (ph != 0) ph <= ph + 1;
      end
   end

   always @(negedge clk) begin
      if (mdl_ok) begin
         int k, r, c, e11, e12, e21, e22, eb, es;
         e11 = 0; e12 = 0; e21 = 0; e22 = 0; eb = 0; es = 0;
         if (ph >= 2 && ph <= 10) begin
            k   = ph - 2;
            r   = k / 3;
            c   = k % 3;
            e11 = am[r*4 + c];
            e12 = am[r*4 + c + 1];
            e21 = am[(r+1)*4 + c];
            e22 = am[(r+1)*4 + c + 1];
            eb  = bm[(2-r)*3 + (2-c)];
            es  = k;
         end
         chk("busy", busy, int'(ph != 0));
         chk("done", done, int'(ph == 12));
         chk("acc_clr", acc_clr, int'(ph == 1 && !stl));
         chk("op_valid", op_valid, int'(ph >= 2 && ph <= 10 && !stl));
         chk("a_11", a_11, e11);
         chk("a_12", a_12, e12);
         chk("a_21", a_21, e21);
         chk("a_22", a_22, e22);
         chk("b_bcast", b_bcast, eb);
         chk("step", step, es);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic sel, input int addr, input int data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = 4'(addr);
      wr_data = 8'(data);
      tick();
      wr_en   = 1'b0;
   endtask

   int cap11 [9], cap12 [9], cap21 [9], cap22 [9], capb [9];
   int nvalid, flush_sum, lat, clr_at;

   // Starts a stream and measures start-to-done latency (edges after the sampling edge).
   task automatic run(input int stall_at, input bit busy_wr, input bit same_wr);
      int stall_left;
      bit armed;
      stall_left = 0;
      armed = (stall_at >= 0);
      for (int i = 0; i < 9; i++) begin
         cap11[i] = -1; cap12[i] = -1; cap21[i] = -1; cap22[i] = -1; capb[i] = -1;
      end
      nvalid = 0; flush_sum = -1; lat = -1; clr_at = -1;
      start = 1'b1;
      if (same_wr) begin
         wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd7;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (acc_clr && clr_at < 0) clr_at = n;
         if (op_valid && step <= 4'd8) begin
            nvalid++;
            cap11[step] = a_11; cap12[step] = a_12; cap21[step] = a_21;
            cap22[step] = a_22; capb[step] = b_bcast;
         end
         if (n == 11 + stall_left) flush_sum = a_11 + a_12 + a_21 + a_22 + b_bcast;
         if (busy_wr) begin
            if (n == 3) begin
               wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd9;
            end else if (n == 4) begin
               wr_sel = 1'b1; wr_addr = 4'd9; wr_data = 8'd5;
            end else if (n == 5) begin
               wr_en = 1'b0; start = 1'b1;
            end else if (n == 6) begin
               start = 1'b0;
            end
         end
         if (stall_left > 0) begin
            chk("stall_step_hold", step, stall_at);
            chk("stall_valid_low", op_valid, 0);
            stall_left--;
            if (stall_left == 0) stall = 1'b0;
         end else if (armed && op_valid && step == 4'(stall_at)) begin
            stall = 1'b1;
            stall_left = 3;
            armed = 0;
         end
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   logic [7:0] ga [16] = '{8'd2, 8'd1, 8'd3, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1,
                           8'd3, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd2};
   logic [7:0] gb [9]  = '{8'd1, 8'd3, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd3};

   initial begin
      int seen_done, got4, capsum;
      // Reset held for two cycles.
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_op_valid", op_valid, 0);
      chk("rst_a_11", a_11, 0);
      chk("rst_step", step, 0);

      // Empty stores stream zeros.
      run(-1, 0, 0);
      chk("empty_latency", lat, 12);
      chk("empty_nvalid", nvalid, 9);
      capsum = 0;
      for (int i = 0; i < 9; i++) capsum += cap11[i] + cap22[i] + capb[i];
      chk("empty_operands", capsum, 0);
      tick();

      // Golden tile and kernel.
      for (int i = 0; i < 16; i++) wr(1'b0, i, int'(ga[i]));
      for (int i = 0; i < 9; i++) wr(1'b1, i, int'(gb[i]));
      run(-1, 0, 0);
      chk("gold_clr_at", clr_at, 1);
      chk("gold_latency", lat, 12);
      chk("gold_s0_a11", cap11[0], 2);
      chk("gold_s0_a12", cap12[0], 1);
      chk("gold_s0_a21", cap21[0], 2);
      chk("gold_s0_a22", cap22[0], 3);
      chk("gold_s0_b", capb[0], 3);
      chk("gold_s4_a11", cap11[4], 3);
      chk("gold_s4_a12", cap12[4], 2);
      chk("gold_s4_a22", cap22[4], 2);
      chk("gold_s4_b", capb[4], 1);
      chk("gold_s8_a11", cap11[8], 2);
      chk("gold_s8_a21", cap21[8], 1);
      chk("gold_s8_a22", cap22[8], 2);
      chk("gold_s8_b", capb[8], 1);
      chk("gold_flush_zero", flush_sum, 0);
      tick();

      // Writes and start while busy are dropped; replay is identical.
      run(-1, 1, 0);
      chk("busy_wr_latency", lat, 12);
      chk("busy_wr_a11", cap11[0], 2);
      tick();
      chk("no_restart", busy, 0);
      run(-1, 0, 0);
      chk("replay_a11", cap11[0], 2);
      chk("replay_b8", capb[8], 1);
      tick();

      // Asynchronous reset at step 4.
      start = 1'b1;
      tick();
      start = 1'b0;
      got4 = 0;
      for (int n = 0; n < 20 && !got4; n++) begin
         tick();
         if (op_valid && step == 4'd4) got4 = 1;
      end
      chk("reached_step4", got4, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_op_valid", op_valid, 0);
      chk("abort_a_11", a_11, 0);
      chk("abort_b", b_bcast, 0);
      chk("abort_step", step, 0);
      tick();
      rst_n = 1'b1;
      seen_done = 0;
      for (int n = 0; n < 15; n++) begin
         tick();
         if (done) seen_done = 1;
      end
      chk("abort_no_done", seen_done, 0);
      run(-1, 0, 0);
      capsum = 0;
      for (int i = 0; i < 9; i++) capsum += cap11[i] + cap12[i] + capb[i];
      chk("cleared_store", capsum, 0);
      tick();

      // Write and start in the same cycle.
      run(-1, 0, 1);
      chk("same_cycle_a11", cap11[0], 7);
      chk("same_cycle_latency", lat, 12);
      tick();

`ifdef SA_FEEDER_STALL_EN
      run(2, 0, 0);
      chk("stall_latency", lat, 15);
      chk("stall_nvalid", nvalid, 9);
      chk("stall_s0_a11", cap11[0], 7);
      tick();
`endif

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
